// File: rtl/imm_pack_loader_pkg.sv
// Shared definitions for the immediate packing loader: immediate-type and
// state encodings plus the per-type immediate bit masks.
package imm_pack_loader_pkg;

    typedef enum logic [1:0] {
        I_TYPE = 2'b00,
        S_TYPE = 2'b01,
        B_TYPE = 2'b10,
        J_TYPE = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Bit positions occupied by the immediate in each instruction format
    localparam logic [31:0] I_MASK = 32'hFFF0_0000;
    localparam logic [31:0] S_MASK = 32'hFE00_0F80;
    localparam logic [31:0] B_MASK = 32'hFE00_0F80;
    localparam logic [31:0] J_MASK = 32'hFFFF_F000;

    function automatic logic [31:0] imm_mask(input imm_src_e src);
        logic [31:0] m;
        case (src)
            I_TYPE:  m = I_MASK;
            S_TYPE:  m = S_MASK;
            B_TYPE:  m = B_MASK;
            default: m = J_MASK;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/imm_pack_loader_imm_pack.sv
// Combinational packer: inserts a signed immediate into the I/S/B/J fields
// of a base instruction word and flags whether the value is encodable.
module imm_pack
    import imm_pack_loader_pkg::*;
(
    input  logic [31:0] base_word,
    input  logic [31:0] imm,
    input  logic [1:0]  imm_src,
    output logic [31:0] word,
    output logic        legal
);

    imm_src_e    src;
    logic [31:0] field;
    logic        fits_12;
    logic        fits_13;
    logic        fits_21;

    assign src = imm_src_e'(imm_src);

    // A value fits in N signed bits when every bit above N-1 matches the sign
    assign fits_12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits_13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits_21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        field = '0;
        legal = 1'b0;
        case (src)
            I_TYPE: begin
                field[31:20] = imm[11:0];
                legal        = fits_12;
            end
            S_TYPE: begin
                field[31:25] = imm[11:5];
                field[11:7]  = imm[4:0];
                legal        = fits_12;
            end
            B_TYPE: begin
                field[31]    = imm[12];
                field[30:25] = imm[10:5];
                field[11:8]  = imm[4:1];
                field[7]     = imm[11];
                legal        = fits_13 & ~imm[0];
            end
            default: begin
                field[31]    = imm[20];
                field[30:21] = imm[10:1];
                field[20]    = imm[11];
                field[19:12] = imm[19:12];
                legal        = fits_21 & ~imm[0];
            end
        endcase
    end

    assign word = (base_word & ~imm_mask(src)) | field;

endmodule

// File: rtl/imm_pack_loader.sv
// Streaming loader: accepts (base_word, imm, type) beats, packs legal ones and
// writes them to consecutive instruction-memory slots, tallying rejected beats.
module imm_pack_loader
    import imm_pack_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        imm_src,
    input  logic [31:0]       imm,
    input  logic [31:0]       base_word,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] err_addr
);

    state_e            state_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic [CNT_W-1:0]  remaining_reg;
    logic              in_ready_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;
    logic [CNT_W-1:0]  err_cnt_reg;
    logic [ADDR_W-1:0] err_addr_reg;

    logic [31:0]       packed_word;
    logic              packed_legal;
    logic              handshake;

    imm_pack u_imm_pack (
        .base_word (base_word),
        .imm       (imm),
        .imm_src   (imm_src),
        .word      (packed_word),
        .legal     (packed_legal)
    );

    assign handshake = in_valid && in_ready_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= '0;
            remaining_reg <= '0;
            in_ready_reg  <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            err_cnt_reg   <= '0;
            err_addr_reg  <= '0;
        end else begin
            mem_we_reg <= 1'b0;
            done_reg   <= 1'b0;
            // busy stays up through the done pulse and drops with it
            if (done_reg) begin
                busy_reg <= 1'b0;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        busy_reg      <= 1'b1;
                        err_reg       <= 1'b0;
                        err_cnt_reg   <= '0;
                        ptr_reg       <= base_addr;
                        remaining_reg <= count;
                        if (count == '0) begin
                            state_reg <= ST_DONE;
                        end else begin
                            state_reg    <= ST_LOAD;
                            in_ready_reg <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (handshake) begin
                        // The pointer advances on rejected beats too, keeping slots 1:1 with beats
                        ptr_reg       <= ptr_reg + 1'b1;
                        remaining_reg <= remaining_reg - 1'b1;
                        if (packed_legal) begin
                            mem_we_reg    <= 1'b1;
                            mem_addr_reg  <= ptr_reg;
                            mem_wdata_reg <= packed_word;
                        end else begin
                            err_reg <= 1'b1;
                            if (err_cnt_reg != {CNT_W{1'b1}}) begin
                                err_cnt_reg <= err_cnt_reg + 1'b1;
                            end
                            if (!err_reg) begin
                                err_addr_reg <= ptr_reg;
                            end
                        end
                        if (remaining_reg == CNT_W'(1)) begin
                            state_reg    <= ST_DONE;
                            in_ready_reg <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    in_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign err_cnt   = err_cnt_reg;
    assign err_addr  = err_addr_reg;

endmodule

// File: tb/tb_imm_pack_loader.sv
// Scoreboard bench for imm_pack_loader: expected writes are queued at each
// handshake and matched against mem_we cycles by a negedge monitor.
module tb_imm_pack_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [9:0]  count;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  imm_src;
    logic [31:0] imm;
    logic [31:0] base_word;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [9:0]  err_cnt;
    logic [9:0]  err_addr;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int wr_cnt   = 0;

    logic [9:0] exp_ptr      = '0;
    logic       exp_err      = 1'b0;
    logic [9:0] exp_err_cnt  = '0;
    logic [9:0] exp_err_addr = '0;

    imm_pack_loader #(.ADDR_W(10), .CNT_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_src   (imm_src),
        .imm       (imm),
        .base_word (base_word),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_cnt   (err_cnt),
        .err_addr  (err_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference packer built by field concatenation; returns {legal, word}
    function automatic logic [32:0] model(input logic [1:0] src, input logic [31:0] bw,
                                          input logic [31:0] im);
        int          v;
        logic        ok;
        logic [31:0] w;
        v = $signed(im);
        case (src)
            2'b00: begin
                ok = (v >= -2048) && (v <= 2047);
                w  = {im[11:0], bw[19:0]};
            end
            2'b01: begin
                ok = (v >= -2048) && (v <= 2047);
                w  = {im[11:5], bw[24:12], im[4:0], bw[6:0]};
            end
            2'b10: begin
                ok = (v >= -4096) && (v <= 4094) && (im[0] == 1'b0);
                w  = {im[12], im[10:5], bw[24:12], im[4:1], im[11], bw[6:0]};
            end
            default: begin
                ok = (v >= -1048576) && (v <= 1048574) && (im[0] == 1'b0);
                w  = {im[20], im[10:1], im[11], im[19:12], bw[11:0]};
            end
        endcase
        return {ok, w};
    endfunction

    // Write monitor: every mem_we cycle must match the oldest queued write
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (mem_we) begin
                wr_cnt++;
                $display("write addr=0x%03h data=0x%08h", mem_addr, mem_wdata);
                if (sb_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("mem_addr", 32'(mem_addr), 32'(e.addr));
                    check("mem_wdata", mem_wdata, e.data);
                end
            end
        end
    end

    task automatic start_burst(input logic [9:0] ba, input logic [9:0] cnt);
        start       = 1'b1;
        base_addr   = ba;
        count       = cnt;
        exp_ptr     = ba;
        exp_err     = 1'b0;
        exp_err_cnt = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [1:0] src, input logic [31:0] bw, input logic [31:0] im);
        logic [32:0] r;
        bit          seen;
        wr_t         e;
        in_valid  = 1'b1;
        imm_src   = src;
        base_word = bw;
        imm       = im;
        seen      = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check("in_ready_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            r = model(src, bw, im);
            $display("beat slot=0x%03h src=%0d imm=%0d legal=%0d", exp_ptr, src, $signed(im), r[32]);
            if (r[32]) begin
                e.addr = exp_ptr;
                e.data = r[31:0];
                sb_q.push_back(e);
            end else begin
                if (!exp_err) exp_err_addr = exp_ptr;
                exp_err = 1'b1;
                if (exp_err_cnt != 10'h3FF) exp_err_cnt = exp_err_cnt + 1'b1;
            end
            exp_ptr = exp_ptr + 1'b1;
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_burst(input int dcnt_before);
        @(negedge clk);
        check("done_early", 32'(done), 32'd0);
        check("busy_run", 32'(busy), 32'd1);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("done_clear", 32'(done), 32'd0);
        check("busy_clear", 32'(busy), 32'd0);
        check("in_ready_idle", 32'(in_ready), 32'd0);
        check("done_count", 32'(done_cnt - dcnt_before), 32'd1);
        check("err", 32'(err), 32'(exp_err));
        check("err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
        check("err_addr", 32'(err_addr), 32'(exp_err_addr));
        check("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        check({tag, "_err_addr"}, 32'(err_addr), 32'd0);
    endtask

    initial begin
        int d0;
        int w0;
        int bnd[10] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -4098, -1048576, 1048574};
        int v;

        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;
        in_valid  = 1'b0;
        imm_src   = '0;
        imm       = '0;
        base_word = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single I beat
        d0 = done_cnt;
        start_burst(10'h010, 10'd1);
        send_beat(2'b00, 32'h0000_0013, 32'hFFFF_FFFF);
        finish_burst(d0);

        // S, B, J legal then J out of range
        d0 = done_cnt;
        start_burst(10'h100, 10'd4);
        send_beat(2'b01, 32'h0000_2023, 32'd8);
        send_beat(2'b10, 32'h0000_0063, 32'hFFFF_FFFC);
        send_beat(2'b11, 32'h0000_006F, 32'd2048);
        send_beat(2'b11, 32'h0000_006F, 32'd1048576);
        finish_burst(d0);

        // Middle beat rejected: writes only at slots 0 and 2
        d0 = done_cnt;
        start_burst(10'h200, 10'd3);
        send_beat(2'b00, 32'h0000_0013, 32'd5);
        send_beat(2'b00, 32'h0000_0013, 32'd2048);
        send_beat(2'b00, 32'h0000_0013, 32'hFFFF_F800);
        finish_burst(d0);

        // Odd B offset rejected, then the largest legal B offset
        d0 = done_cnt;
        start_burst(10'h050, 10'd2);
        send_beat(2'b10, 32'h0000_0063, 32'd3);
        send_beat(2'b10, 32'hFFFF_FFE3, 32'd4094);
        finish_burst(d0);

        // Empty burst clears err and err_cnt but writes nothing
        d0 = done_cnt;
        w0 = wr_cnt;
        start_burst(10'h077, 10'd0);
        finish_burst(d0);
        check("empty_no_write", 32'(wr_cnt - w0), 32'd0);

        // Address wrap
        d0 = done_cnt;
        start_burst(10'h3FF, 10'd2);
        send_beat(2'b11, 32'h0000_0EEF, 32'hFFF0_0000);
        send_beat(2'b01, 32'h00A5_2023, 32'hFFFF_F800);
        finish_burst(d0);

        // Mixed random beats, back to back
        d0 = done_cnt;
        start_burst(10'h123, 10'd12);
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 2))
                0:       v = bnd[$urandom_range(0, 9)];
                1:       v = int'($urandom_range(0, 8000)) - 4000;
                default: v = int'($urandom);
            endcase
            send_beat(2'($urandom_range(0, 3)), $urandom, 32'(v));
        end
        finish_burst(d0);

        // in_valid in IDLE is ignored
        w0 = wr_cnt;
        in_valid  = 1'b1;
        imm_src   = 2'b00;
        imm       = 32'd1;
        base_word = 32'h0000_0013;
        repeat (5) @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        check("idle_no_write", 32'(wr_cnt - w0), 32'd0);

        // Reset in the middle of a burst
        d0 = done_cnt;
        start_burst(10'h020, 10'd4);
        send_beat(2'b00, 32'h0000_0013, 32'd100);
        send_beat(2'b00, 32'h0000_0093, 32'hFFFF_FF00);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        check("midrst_idle_busy", 32'(busy), 32'd0);
        exp_err_addr = '0;

        // Recovery after reset
        d0 = done_cnt;
        start_burst(10'h030, 10'd1);
        send_beat(2'b01, 32'h0000_2023, 32'd2047);
        finish_burst(d0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
